// File: rtl/bcd_xs3_seq_ctrl_if.sv
// Handshake bundle between a BCD source, the excess-3 sequencer and its consumer.
// The slave modport is the sequencer; the master modport is the source/consumer side.
interface bcd_xs3_seq_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_bcd;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_xs3;
    logic                  out_err;
    logic                  busy;

    modport slave (
        input  in_valid,
        input  in_bcd,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_xs3,
        output out_err,
        output busy
    );

    modport master (
        output in_valid,
        output in_bcd,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_xs3,
        input  out_err,
        input  busy
    );
endinterface

// File: rtl/bcd_xs3_seq_ctrl.sv
// BCD-to-excess-3 sequencer: one shared add-3 unit walks the latched word one digit
// per clock, LSB digit first, then holds the result until the consumer takes it.
module bcd_xs3_seq_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_xs3_seq_ctrl_if.slave bus
);
    localparam int DW   = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The shared add-3 unit; illegal digits wrap modulo 16.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return d + 4'd3;
    endfunction

    function automatic logic digit_illegal(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    state_t          state_r;
    state_t          state_nxt_s;
    logic            accept_s;
    logic [3:0]      digit_s;
    logic [IDXW-1:0] idx_r;
    logic [DW-1:0]   bcd_r;
    logic [DW-1:0]   xs3_r;
    logic            err_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;

    // Digit currently presented to the add-3 unit.
    always_comb begin
        digit_s = bcd_r[{idx_r, 2'b00} +: 4];
    end

    // Next-state logic; in_valid outside IDLE and out_ready outside DONE are ignored.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_CONV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Datapath: latch on accept, convert one digit per CONV cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_r <= {DW{1'b0}};
            xs3_r <= {DW{1'b0}};
            err_r <= 1'b0;
            idx_r <= {IDXW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        bcd_r <= bus.in_bcd;
                        xs3_r <= {DW{1'b0}};
                        err_r <= 1'b0;
                        idx_r <= {IDXW{1'b0}};
                    end
                end
                ST_CONV: begin
                    xs3_r[{idx_r, 2'b00} +: 4] <= add3(digit_s);
                    err_r <= err_r | digit_illegal(digit_s);
                    if (idx_r != IDX_LAST) begin
                        idx_r <= idx_r + IDX_ONE;
                    end
                end
                ST_DONE: begin
                    err_r <= err_r;
                end
                default: begin
                    idx_r <= {IDXW{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_xs3   = xs3_r;
    assign bus.out_err   = err_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Bench for bcd_xs3_seq_ctrl: directed scenarios plus randomized words, checked
// against an arithmetic per-digit reference model and expected handshake timing.
module tb_bcd_xs3_seq_ctrl;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    bcd_xs3_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_xs3_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: every digit plus three, modulo sixteen.
    function automatic logic [W-1:0] ref_xs3(input logic [W-1:0] w);
        int acc = 0;
        int scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = (int'(w) / scale) % 16;
            acc += ((d + 3) % 16) * scale;
            scale *= 16;
        end
        return W'(acc);
    endfunction

    function automatic logic ref_err(input logic [W-1:0] w);
        int scale = 1;
        logic e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((int'(w) / scale) % 16 > 9) e = 1'b1;
            scale *= 16;
        end
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"},  bus.in_ready,  1);
        check_val({tag, "_out_valid"}, bus.out_valid, 0);
        check_val({tag, "_out_xs3"},   bus.out_xs3,   0);
        check_val({tag, "_out_err"},   bus.out_err,   0);
        check_val({tag, "_busy"},      bus.busy,      0);
    endtask

    // Wait (bounded) for out_valid; lat = cycles since the accept edge, 0 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_valid) begin
                lat = i;
                break;
            end
            check_val("conv_in_ready", bus.in_ready, 0);
            check_val("conv_busy", bus.busy, 1);
        end
        if (lat == 0) check_val("valid_timeout", 0, 1);
    endtask

    // Offer one word from IDLE, check result and timing, stall the consumer, release.
    task automatic run_word(input logic [W-1:0] w, input int stall,
                            input logic [W-1:0] offer, input logic use_offer);
        int lat;
        logic [W-1:0] exp_x;
        logic exp_e;
        exp_x = ref_xs3(w);
        exp_e = ref_err(w);
        check_val("idle_in_ready", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.in_bcd    = w;
        bus.out_ready = (stall == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bcd   = W'($urandom);
        check_val("accept_busy", bus.busy, 1);
        wait_valid(lat);
        check_val("latency", lat, DIGITS);
        check_val("xs3", bus.out_xs3, exp_x);
        check_val("err", bus.out_err, exp_e);
        if (use_offer) begin
            bus.in_valid = 1'b1;
            bus.in_bcd   = offer;
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            check_val("hold_valid", bus.out_valid, 1);
            check_val("hold_xs3", bus.out_xs3, exp_x);
            check_val("hold_err", bus.out_err, exp_e);
            check_val("hold_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("release_valid", bus.out_valid, 0);
        check_val("release_in_ready", bus.in_ready, 1);
        check_val("release_busy", bus.busy, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        int lat;
        int cyc0;
        logic [W-1:0] w;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcd    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("por");

        // Reset held two cycles in the middle of a conversion.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h4321;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("mid_rst");

        run_word(16'h1234, 0, 16'h0000, 1'b0);

        // Back-to-back words with out_ready and in_valid held high.
        bus.in_valid  = 1'b1;
        bus.in_bcd    = 16'h0000;
        bus.out_ready = 1'b1;
        tick();
        cyc0 = cyc;
        bus.in_bcd = 16'h9090;
        wait_valid(lat);
        check_val("b2b_lat", lat, DIGITS);
        check_val("b2b_xs3_a", bus.out_xs3, ref_xs3(16'h0000));
        check_val("b2b_err_a", bus.out_err, 0);
        tick();
        check_val("b2b_gap_valid", bus.out_valid, 0);
        check_val("b2b_gap_ready", bus.in_ready, 1);
        tick();
        check_val("b2b_accept_busy", bus.busy, 1);
        check_val("b2b_spacing", cyc - cyc0, DIGITS + 2);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check_val("b2b_xs3_b", bus.out_xs3, 16'hC3C3);
        check_val("b2b_err_b", bus.out_err, 0);
        tick();
        bus.out_ready = 1'b0;

        // Illegal digit, then the error flag clears on the next word.
        run_word(16'h12A4, 0, 16'h0000, 1'b0);
        run_word(16'h0001, 1, 16'h0000, 1'b0);

        // Consumer stall with a concurrent offer that must be ignored until IDLE.
        run_word(16'h0042, 5, 16'h0777, 1'b1);
        run_word(16'h0777, 0, 16'h0000, 1'b0);

        // Reset at idx 2 aborts the word.
        bus.in_valid = 1'b1;
        bus.in_bcd   = 16'h5678;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("abort_rst");
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("abort_no_valid", bus.out_valid, 0);
        end
        run_word(16'h8765, 1, 16'h0000, 1'b0);

        // Randomized words, mostly legal BCD with some illegal digits.
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                w[4*i +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            run_word(w, $urandom_range(0, 3), W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
